alu_74181_nibble_serial: RTL and testbench
==========================================

Name: alu_74181_nibble_serial

Overview:
- Multi-nibble ALU engine built on 74181 function semantics. Processes a 4*NIBBLES-bit operation one nibble per clock, LSB nibble first.
- The ripple carry between nibbles is held in a register, so one 4-bit 74181 slice is reused across cycles instead of cascading parallel slices.
- Sits behind the TinyTapeout top-level pin wrapper and drives the operands/results of the ALU core through a valid/ready handshake.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation (legal 1..8); W = 4*NIBBLES.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  engine can accept; equals (state==IDLE)
- a  in  W  operand A (active-high data)
- b  in  W  operand B
- s  in  4  74181 function select S3..S0
- m  in  1  mode: 1 = logic, 0 = arithmetic
- cn  in  1  carry-in, active-low (cn=0 means +1)
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- f  out  W  result
- cn_out  out  1  carry-out of MSB slice, active-low
- p_n  out  1  word group propagate, active-low
- g_n  out  1  word group generate, active-low
- aeqb  out  1  &f (all-ones result)
- ovf  out  1  signed overflow (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, out_valid=0, f=0, cn_out=1, p_n=1, g_n=1, aeqb=0, ovf=0.
  - All internal operand, carry, index and accumulator registers cleared.
- States:
  - IDLE: in_ready=1. in_valid at a clk edge latches a, b, s, m, cn; sets carry c=~cn, nibble index k=0, Pacc=1, Gacc=0; goes to CALC.
  - CALC: one nibble per cycle, k=0..NIBBLES-1. After slice NIBBLES-1, goes to DONE.
  - DONE: out_valid=1; all outputs held stable. out_ready=1 at an edge returns to IDLE. A new request is accepted no earlier than the following cycle.
- Latency: out_valid rises on edge T0+NIBBLES, where T0 is the accepting edge. Throughput is one operation per NIBBLES+2 cycles, assuming out_ready=1.
- Per-bit slice equations (i within nibble, c_i incoming carry, active-high internally):
  - p_i = A_i | (B_i & S0) | (~B_i & S1)
  - g_i = (A_i & ~B_i & S2) | (A_i & B_i & S3)
  - F_i = p_i ^ g_i ^ (m | c_i)
  - c_{i+1} = g_i | (p_i & c_i)
- Carry:
  - The carry chain always runs; m does not gate cn_out.
  - The registered carry after slice k feeds slice k+1.
  - cn_out = ~c_W.
- Group terms: for each nibble, P = &p and G = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0. Accumulate Gacc <= G | (P & Gacc), Pacc <= P & Pacc. At DONE, p_n=~Pacc, g_n=~Gacc.
- Result bits: f nibble k is written in CALC cycle k. f is only guaranteed valid while out_valid=1. aeqb is computed from the final f.
- Input stability: inputs are sampled only at acceptance; changes on a/b/s/m/cn during CALC/DONE have no effect.
- in_valid outside IDLE is ignored; no queueing.
- NIBBLES=1: CALC lasts exactly one cycle.
- Reset mid-CALC or mid-DONE aborts the operation immediately to reset values; no partial result is ever flagged valid.

Optional Feature:
- Macro ALU_OVF_EN.
- Defined: ovf = c_W ^ c_{W-1}, registered at DONE entry when m=0; ovf=0 when m=1.
- Undefined: ovf tied to 0 and no extra carry register is built. The port is always present.

Test Plan:
- Add, NIBBLES=4, s=1001 m=0 cn=1, a=0x1234 b=0x0FF0 -> f=0x2224, cn_out=1, out_valid rises exactly 4 edges after accept.
- Carry-out, s=1001 m=0 cn=1, a=0xFFFF b=0x0001 -> f=0x0000, cn_out=0, g_n=0, aeqb=0; ovf=0 with ALU_OVF_EN.
- Compare, s=0110 m=0 cn=1, a=b=0x5A5A -> f=0xFFFF (A-B-1), aeqb=1, cn_out=1; repeat with cn=0 -> f=0x0000, cn_out=0.
- Logic XOR, s=0110 m=1, a=0xF0F0 b=0xFF00 -> f=0x0FF0; s=0000 m=1 a=0x1234 -> f=0xEDCB.
- Backpressure, out_ready=0 for 5 cycles in DONE with in_valid=1 and changing a -> out_valid and f held, in_ready=0, nothing accepted; out_ready=1 -> in_ready=1 next cycle.
- Reset mid-CALC (rst_n low during 2nd CALC cycle) -> out_valid=0, f=0, in_ready=1; next add a=0x7FFF b=0x0001 -> f=0x8000, ovf=1 only if ALU_OVF_EN defined.

Source files
------------

// File: rtl/alu_74181_nibble_serial_if.sv
// Handshake and operand/result bundle for the nibble-serial 74181 ALU engine.
interface alu_74181_nibble_serial_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   s;
  logic         m;
  logic         cn;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic         cn_out;
  logic         p_n;
  logic         g_n;
  logic         aeqb;
  logic         ovf;

  modport master (
    output in_valid, a, b, s, m, cn, out_ready,
    input  in_ready, out_valid, f, cn_out, p_n, g_n, aeqb, ovf
  );

  modport slave (
    input  in_valid, a, b, s, m, cn, out_ready,
    output in_ready, out_valid, f, cn_out, p_n, g_n, aeqb, ovf
  );
endinterface

// File: rtl/alu_74181_nibble_serial.sv
// Nibble-serial 74181 ALU: one 4-bit slice reused per cycle, carry held in a register.
// Optional signed-overflow flag enabled by defining ALU_OVF_EN.
module alu_74181_nibble_serial #(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  alu_74181_nibble_serial_if.slave  bus
);
  localparam int W = 4 * NIBBLES;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] f_q, f_d;
  logic [3:0]   s_q, s_d;
  logic         m_q, m_d;
  logic         c_q, c_d;
  logic         pacc_q, pacc_d;
  logic         gacc_q, gacc_d;
  logic [2:0]   k_q, k_d;
  logic         ovf_q, ovf_d;

  logic [3:0]   an, bn, pv, gv, fn;
  logic [4:0]   cv;
  logic         grp_p, grp_g;

  // Slice for the nibble currently selected by k_q.
  always_comb begin
    an = '0;
    bn = '0;
    for (int unsigned j = 0; j < NIBBLES; j++) begin
      if (k_q == 3'(j)) begin
        an = a_q[4*j +: 4];
        bn = b_q[4*j +: 4];
      end
    end
    pv = '0;
    gv = '0;
    fn = '0;
    cv = '0;
    cv[0] = c_q;
    for (int unsigned i = 0; i < 4; i++) begin
      pv[i]   = an[i] | (bn[i] & s_q[0]) | (~bn[i] & s_q[1]);
      gv[i]   = (an[i] & ~bn[i] & s_q[2]) | (an[i] & bn[i] & s_q[3]);
      fn[i]   = pv[i] ^ gv[i] ^ (m_q | cv[i]);
      cv[i+1] = gv[i] | (pv[i] & cv[i]);
    end
    grp_p = &pv;
    grp_g = gv[3] | (pv[3] & gv[2]) | (pv[3] & pv[2] & gv[1]) |
            (pv[3] & pv[2] & pv[1] & gv[0]);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    f_d     = f_q;
    s_d     = s_q;
    m_d     = m_q;
    c_d     = c_q;
    pacc_d  = pacc_q;
    gacc_d  = gacc_q;
    k_d     = k_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          s_d     = bus.s;
          m_d     = bus.m;
          c_d     = ~bus.cn;
          k_d     = '0;
          pacc_d  = 1'b1;
          gacc_d  = 1'b0;
          f_d     = '0;
          ovf_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        for (int unsigned j = 0; j < NIBBLES; j++) begin
          if (k_q == 3'(j)) f_d[4*j +: 4] = fn;
        end
        c_d    = cv[4];
        pacc_d = grp_p & pacc_q;
        gacc_d = grp_g | (grp_p & gacc_q);
        if (k_q == 3'(NIBBLES - 1)) begin
          ovf_d   = ~m_q & (cv[4] ^ cv[3]);
          state_d = DONE;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      c_q     <= 1'b0;
      pacc_q  <= 1'b0;
      gacc_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      s_q     <= s_d;
      m_q     <= m_d;
      c_q     <= c_d;
      pacc_q  <= pacc_d;
      gacc_q  <= gacc_d;
      k_q     <= k_d;
    end
  end

`ifdef ALU_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign bus.ovf = ovf_q;
`else
  assign ovf_q   = 1'b0;
  assign bus.ovf = 1'b0;
`endif

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.f         = f_q;
  assign bus.cn_out    = ~c_q;
  assign bus.p_n       = ~pacc_q;
  assign bus.g_n       = ~gacc_q;
  assign bus.aeqb      = &f_q;

endmodule

// File: tb/tb_alu_74181_nibble_serial.sv
// Directed bench for alu_74181_nibble_serial (NIBBLES=4): vector table plus handshake/reset sequences.
module tb_alu_74181_nibble_serial;
  localparam int NIB = 4;

`ifdef ALU_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_74181_nibble_serial_if #(.NIBBLES(NIB)) bus ();
  alu_74181_nibble_serial #(.NIBBLES(NIB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  s;
    logic        m;
    logic        cn;
    logic [15:0] ef;
    logic        ecn;
    logic        epn;
    logic        egn;
    logic        eaeq;
  } vec_t;

  vec_t vt[8];
  int   total = 0;
  int   bad   = 0;
  int   lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                        input logic m, input logic cn, output int l);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    bus.a = a; bus.b = b; bus.s = s; bus.m = m; bus.cn = cn;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    l = 99;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        l = e;
        break;
      end
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    //        a         b         s     m     cn    f         cn_o  p_n   g_n   aeqb
    vt[0] = '{16'h1234, 16'h0FF0, 4'h9, 1'b0, 1'b1, 16'h2224, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2] = '{16'h5A5A, 16'h5A5A, 4'h6, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[3] = '{16'h5A5A, 16'h5A5A, 4'h6, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[4] = '{16'hF0F0, 16'hFF00, 4'h6, 1'b1, 1'b1, 16'h0FF0, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[5] = '{16'h1234, 16'h0000, 4'h0, 1'b1, 1'b1, 16'hEDCB, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[6] = '{16'h0005, 16'h0003, 4'h6, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[7] = '{16'hF0F0, 16'h3C3C, 4'hB, 1'b1, 1'b1, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.s = '0; bus.m = 1'b0; bus.cn = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_f", 32'(bus.f), 32'h0);
    chk("rst_cn_out", 32'(bus.cn_out), 32'd1);
    chk("rst_p_n", 32'(bus.p_n), 32'd1);
    chk("rst_g_n", 32'(bus.g_n), 32'd1);
    chk("rst_aeqb", 32'(bus.aeqb), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      run_op(vt[v].a, vt[v].b, vt[v].s, vt[v].m, vt[v].cn, lat);
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'd4);
      chk($sformatf("v%0d_f", v), 32'(bus.f), 32'(vt[v].ef));
      chk($sformatf("v%0d_cn_out", v), 32'(bus.cn_out), 32'(vt[v].ecn));
      chk($sformatf("v%0d_p_n", v), 32'(bus.p_n), 32'(vt[v].epn));
      chk($sformatf("v%0d_g_n", v), 32'(bus.g_n), 32'(vt[v].egn));
      chk($sformatf("v%0d_aeqb", v), 32'(bus.aeqb), 32'(vt[v].eaeq));
      chk($sformatf("v%0d_ovf", v), 32'(bus.ovf), 32'd0);
      chk($sformatf("v%0d_in_ready", v), 32'(bus.in_ready), 32'd0);
      release_out();
    end

    // Backpressure: DONE held while new requests and operand changes are ignored.
    run_op(16'h1111, 16'h2222, 4'h9, 1'b0, 1'b1, lat);
    chk("bp_latency", 32'(lat), 32'd4);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.a = 16'($urandom);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_out_valid", c), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp%0d_f", c), 32'(bus.f), 32'h3333);
      chk($sformatf("bp%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    release_out();
    chk("bp_rel_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_rel_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Reset asserted during the second CALC cycle.
    bus.a = 16'h1234; bus.b = 16'h0FF0; bus.s = 4'h9; bus.m = 1'b0; bus.cn = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_f", 32'(bus.f), 32'h0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_cn_out", 32'(bus.cn_out), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(16'h7FFF, 16'h0001, 4'h9, 1'b0, 1'b1, lat);
    chk("post_rst_latency", 32'(lat), 32'd4);
    chk("post_rst_f", 32'(bus.f), 32'h8000);
    chk("post_rst_cn_out", 32'(bus.cn_out), 32'd1);
    chk("post_rst_ovf", 32'(bus.ovf), 32'(OVF_ON));
    release_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
